// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, reset values,
// memory op codes and the access FSM state type.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational op decode, big-endian byte-lane select, store replication
// and load extension for the memory stage.
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] store_data,
    input  logic [RegBus-1:0] rdata,
    output logic              is_mem,
    output logic              is_load,
    output logic              is_store,
    output logic              misaligned,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  byte_sel_s;
    logic [3:0]  half_sel_s;

    // Pick the addressed lane out of the read word; lane 0 is the MSB byte.
    always_comb begin
        byte_s     = 8'h00;
        byte_sel_s = 4'b0000;
        case (addr_lo)
            2'b00: begin byte_s = rdata[31:24]; byte_sel_s = 4'b1000; end
            2'b01: begin byte_s = rdata[23:16]; byte_sel_s = 4'b0100; end
            2'b10: begin byte_s = rdata[15:8];  byte_sel_s = 4'b0010; end
            2'b11: begin byte_s = rdata[7:0];   byte_sel_s = 4'b0001; end
            default: begin byte_s = 8'h00; byte_sel_s = 4'b0000; end
        endcase
        if (addr_lo[1]) begin
            half_s     = rdata[15:0];
            half_sel_s = 4'b0011;
        end else begin
            half_s     = rdata[31:16];
            half_sel_s = 4'b1100;
        end
    end

    // Decode the op into access class, enables, store data and load result.
    always_comb begin
        is_mem     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel        = 4'b0000;
        wdata      = ZeroWord;
        load_data  = ZeroWord;
        case (aluop)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem    = 1'b1;
                is_load   = 1'b1;
                sel       = byte_sel_s;
                load_data = (aluop == EXE_LB_OP) ? {{24{byte_s[7]}}, byte_s}
                                                 : {24'h00_0000, byte_s};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                misaligned = addr_lo[0];
                sel        = half_sel_s;
                load_data  = (aluop == EXE_LH_OP) ? {{16{half_s[15]}}, half_s}
                                                  : {16'h0000, half_s};
            end
            EXE_LW_OP: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                misaligned = (addr_lo != 2'b00);
                sel        = 4'b1111;
                load_data  = rdata;
            end
            EXE_SB_OP: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                sel      = byte_sel_s;
                wdata    = {4{store_data[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misaligned = addr_lo[0];
                sel        = half_sel_s;
                wdata      = {2{store_data[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misaligned = (addr_lo != 2'b00);
                sel        = 4'b1111;
                wdata      = store_data;
            end
            default: begin
                is_mem = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data bus for loads/stores, stalls
// the pipe while waiting for ack, and abandons the access after TIMEOUT.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd_addr,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [7:0]            ex_aluop,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_reg2,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [RegBus-1:0]     dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [RegBus-1:0]     dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [RegBus-1:0]     dbus_rdata,
    output logic [RegAddrBus-1:0] mem_wd_addr,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  stallreq,
    output logic                  mem_align_err,
    output logic                  mem_bus_err
);

    mem_state_e        state_r;
    logic [7:0]        cnt_r;
    logic              is_mem_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              misaligned_s;
    logic [3:0]        sel_s;
    logic [RegBus-1:0] wdata_s;
    logic [RegBus-1:0] load_data_s;
    logic              go_s;
    logic              timeout_s;

    mem_lane_fmt u_lane_fmt (
        .aluop      (ex_aluop),
        .addr_lo    (ex_mem_addr[1:0]),
        .store_data (ex_reg2),
        .rdata      (dbus_rdata),
        .is_mem     (is_mem_s),
        .is_load    (is_load_s),
        .is_store   (is_store_s),
        .misaligned (misaligned_s),
        .sel        (sel_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s)
    );

    // cnt_r counts WAIT cycles already spent, so +1 includes the current one.
    assign go_s      = is_mem_s & ~misaligned_s;
    assign timeout_s = (state_r == ST_WAIT) &&
                       (({1'b0, cnt_r} + 9'd1) == {1'b0, TIMEOUT});

    // Access FSM and wait counter; ack always wins over timeout.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s && !dbus_ack) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!go_s || dbus_ack || timeout_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // Bus, stall and writeback outputs; reset gates everything to idle values.
    always_comb begin
        dbus_req      = 1'b0;
        dbus_we       = 1'b0;
        dbus_addr     = ZeroWord;
        dbus_sel      = 4'b0000;
        dbus_wdata    = ZeroWord;
        stallreq      = 1'b0;
        mem_align_err = 1'b0;
        mem_bus_err   = 1'b0;
        mem_wd_addr   = ex_wd_addr;
        mem_wreg      = ex_wreg;
        mem_wdata     = ex_wdata;
        if (rst == RstEnable) begin
            mem_wd_addr = NOPRegAddr;
            mem_wreg    = WriteDisable;
            mem_wdata   = ZeroWord;
        end else if (!is_mem_s) begin
            mem_wreg = ex_wreg;
        end else if (misaligned_s) begin
            mem_align_err = 1'b1;
            mem_wreg      = WriteDisable;
            mem_wdata     = ZeroWord;
        end else if (dbus_ack) begin
            dbus_req   = 1'b1;
            dbus_we    = is_store_s;
            dbus_addr  = {ex_mem_addr[31:2], 2'b00};
            dbus_sel   = sel_s;
            dbus_wdata = wdata_s;
            mem_wreg   = is_load_s ? ex_wreg : WriteDisable;
            mem_wdata  = is_load_s ? load_data_s : ZeroWord;
        end else if (timeout_s) begin
            mem_bus_err = 1'b1;
            mem_wreg    = WriteDisable;
            mem_wdata   = ZeroWord;
        end else begin
            dbus_req   = 1'b1;
            dbus_we    = is_store_s;
            dbus_addr  = {ex_mem_addr[31:2], 2'b00};
            dbus_sel   = sel_s;
            dbus_wdata = wdata_s;
            stallreq   = 1'b1;
            mem_wreg   = WriteDisable;
            mem_wdata  = ZeroWord;
        end
    end

endmodule
